// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI-lite read port between instruction fetch
// (requester 0) and the load unit (requester 1). Round-robin grant, one
// transaction in flight, response routed back to the requester that owns it.
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. A valid, once raised, stays high with its payload
// stable until that transfer; ready may depend combinationally on valid.
module mem_read_arbiter #(
   parameter int ALEN = 64,
   parameter int DLEN = 64
) (
   input  logic            clk,
   input  logic            rstn,
   // requester 0 (instruction fetch)
   input  logic            s0_arvalid_i,
   output logic            s0_arready_o,
   input  logic [ALEN-1:0] s0_araddr_i,
   input  logic [2:0]      s0_arprot_i,
   output logic            s0_rvalid_o,
   input  logic            s0_rready_i,
   output logic [DLEN-1:0] s0_rdata_o,
   output logic [1:0]      s0_rresp_o,
   // requester 1 (load unit)
   input  logic            s1_arvalid_i,
   output logic            s1_arready_o,
   input  logic [ALEN-1:0] s1_araddr_i,
   input  logic [2:0]      s1_arprot_i,
   output logic            s1_rvalid_o,
   input  logic            s1_rready_i,
   output logic [DLEN-1:0] s1_rdata_o,
   output logic [1:0]      s1_rresp_o,
   // downstream memory read port
   output logic            m_arvalid_o,
   input  logic            m_arready_i,
   output logic [ALEN-1:0] m_araddr_o,
   output logic [2:0]      m_arprot_o,
   input  logic            m_rvalid_i,
   output logic            m_rready_o,
   input  logic [DLEN-1:0] m_rdata_i,
   input  logic [1:0]      m_rresp_i,
   // debug: current FSM state (0=IDLE, 1=ADDR, 2=RESP)
   output logic [1:0]      state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              m_arvalid_q, m_arvalid_d;
   logic [ALEN-1:0]   m_araddr_q, m_araddr_d;
   logic [2:0]        m_arprot_q, m_arprot_d;
   logic              owner_q, owner_d;
   // last_grant_q = 1 means requester 1 was granted last, so requester 0 wins a tie
   logic              last_grant_q, last_grant_d;

   logic              grant0, grant1;
   logic              s0_hs, s1_hs, ar_hs, r_hs;

   // Round-robin grant: a lone requester wins, a tie goes to the one not granted last
   always_comb begin
      grant0 = s0_arvalid_i & (~s1_arvalid_i | last_grant_q);
      grant1 = s1_arvalid_i & (~s0_arvalid_i | ~last_grant_q);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         m_arvalid_q  <= 1'b0;
         m_araddr_q   <= '0;
         m_arprot_q   <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         m_arvalid_q  <= m_arvalid_d;
         m_araddr_q   <= m_araddr_d;
         m_arprot_q   <= m_arprot_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state logic: accept in IDLE, forward AR in ADDR, wait for R in RESP
   always_comb begin
      state_d      = state_q;
      m_arvalid_d  = m_arvalid_q;
      m_araddr_d   = m_araddr_q;
      m_arprot_d   = m_arprot_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (s0_hs || s1_hs) begin
               state_d      = ADDR;
               m_arvalid_d  = 1'b1;
               owner_d      = s1_hs;
               last_grant_d = s1_hs;
               m_araddr_d   = s1_hs ? s1_araddr_i : s0_araddr_i;
               m_arprot_d   = s1_hs ? s1_arprot_i : s0_arprot_i;
            end
         end
         ADDR: begin
            if (ar_hs) begin
               state_d     = RESP;
               m_arvalid_d = 1'b0;
            end
         end
         RESP: begin
            if (r_hs) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs: grants only in IDLE, response routed to owner only in RESP
   always_comb begin
      s0_arready_o = (state_q == IDLE) & grant0;
      s1_arready_o = (state_q == IDLE) & grant1;
      s0_rvalid_o  = (state_q == RESP) & m_rvalid_i & ~owner_q;
      s1_rvalid_o  = (state_q == RESP) & m_rvalid_i & owner_q;
      m_rready_o   = (state_q == RESP) & (owner_q ? s1_rready_i : s0_rready_i);
      s0_rdata_o   = m_rdata_i;
      s1_rdata_o   = m_rdata_i;
      s0_rresp_o   = m_rresp_i;
      s1_rresp_o   = m_rresp_i;
      m_arvalid_o  = m_arvalid_q;
      m_araddr_o   = m_araddr_q;
      m_arprot_o   = m_arprot_q;
      state_o      = state_q;
      s0_hs        = s0_arvalid_i & s0_arready_o;
      s1_hs        = s1_arvalid_i & s1_arready_o;
      ar_hs        = m_arvalid_q & m_arready_i;
      r_hs         = m_rvalid_i & m_rready_o;
   end

`ifndef SYNTHESIS
   // A response with nothing in flight is a downstream protocol violation
   always @(posedge clk) begin
      if (rstn && m_rvalid_i && (state_q != RESP)) begin
         $error("mem_read_arbiter: m_rvalid asserted outside RESP");
      end
   end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Testbench for mem_read_arbiter: scenario tasks with a response scoreboard
// and an expected-address queue.
module tb_mem_read_arbiter;

   localparam int ALEN = 64;
   localparam int DLEN = 64;
   localparam int W    = 1 + 2 + DLEN;   // {owner, rresp, rdata}

   logic            clk;
   logic            rstn;
   logic            s0_arvalid_i, s0_arready_o, s0_rvalid_o, s0_rready_i;
   logic [ALEN-1:0] s0_araddr_i;
   logic [2:0]      s0_arprot_i;
   logic [DLEN-1:0] s0_rdata_o;
   logic [1:0]      s0_rresp_o;
   logic            s1_arvalid_i, s1_arready_o, s1_rvalid_o, s1_rready_i;
   logic [ALEN-1:0] s1_araddr_i;
   logic [2:0]      s1_arprot_i;
   logic [DLEN-1:0] s1_rdata_o;
   logic [1:0]      s1_rresp_o;
   logic            m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
   logic [ALEN-1:0] m_araddr_o;
   logic [2:0]      m_arprot_o;
   logic [DLEN-1:0] m_rdata_i;
   logic [1:0]      m_rresp_i;
   logic [1:0]      state_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0]      exp_q[$];   // expected responses
   logic [ALEN+2:0]   ar_q[$];    // expected {arprot, araddr} downstream

   mem_read_arbiter #(.ALEN(ALEN), .DLEN(DLEN)) dut (
      .clk(clk), .rstn(rstn),
      .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o),
      .s0_araddr_i(s0_araddr_i), .s0_arprot_i(s0_arprot_i),
      .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i),
      .s0_rdata_o(s0_rdata_o), .s0_rresp_o(s0_rresp_o),
      .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o),
      .s1_araddr_i(s1_araddr_i), .s1_arprot_i(s1_arprot_i),
      .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i),
      .s1_rdata_o(s1_rdata_o), .s1_rresp_o(s1_rresp_o),
      .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
      .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o),
      .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
      .state_o(state_o)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      s0_arvalid_i = 1'b0; s0_araddr_i = '0; s0_arprot_i = '0; s0_rready_i = 1'b0;
      s1_arvalid_i = 1'b0; s1_araddr_i = '0; s1_arprot_i = '0; s1_rready_i = 1'b0;
      m_arready_i  = 1'b0; m_rvalid_i  = 1'b0; m_rdata_i   = '0; m_rresp_i   = '0;
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      idle_inputs();
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // Present a downstream response with random data and record what the owner must see
   task automatic drive_resp(input logic owner, input logic [1:0] resp);
      m_rvalid_i = 1'b1;
      m_rdata_i  = {$urandom, $urandom};
      m_rresp_i  = resp;
      exp_q.push_back({owner, resp, m_rdata_i});
   endtask

   // Sample {s0_rvalid, s1_rvalid, rresp, rdata} as seen on the given requester port
   function automatic logic [W:0] resp_seen(input logic owner);
      if (owner) return {s0_rvalid_o, s1_rvalid_o, s1_rresp_o, s1_rdata_o};
      else       return {s0_rvalid_o, s1_rvalid_o, s0_rresp_o, s0_rdata_o};
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      tick();
      tick();
      settle();
      n_checks++;
      if ({m_arvalid_o, m_arprot_o, m_araddr_o} !== '0) begin
         n_errors++;
         $display("FAIL reset_ar: got valid=%b prot=%h addr=%h want all 0", m_arvalid_o, m_arprot_o, m_araddr_o);
      end
      n_checks++;
      if ({s0_arready_o, s1_arready_o, s0_rvalid_o, s1_rvalid_o, m_rready_o, state_o} !== 7'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got arready=%b%b rvalid=%b%b m_rready=%b state=%0d want 0",
                  s0_arready_o, s1_arready_o, s0_rvalid_o, s1_rvalid_o, m_rready_o, state_o);
      end
      rstn = 1'b1;
   endtask

   task automatic test_single();
      logic [ALEN+2:0] ea;
      logic [W-1:0]    e;
      idle_inputs();
      s0_arvalid_i = 1'b1; s0_araddr_i = 64'h1000; s0_arprot_i = 3'b100;
      ar_q.push_back({3'b100, 64'h1000});
      settle();
      n_checks++;
      if ({s0_arready_o, s1_arready_o} !== 2'b10) begin
         n_errors++;
         $display("FAIL single_grant: got arready=%b%b want 10", s0_arready_o, s1_arready_o);
      end
      tick();
      s0_arvalid_i = 1'b0; s0_araddr_i = '0; s0_arprot_i = '0; m_arready_i = 1'b1;
      settle();
      ea = 'x;
      if (ar_q.size() != 0) ea = ar_q.pop_front();
      n_checks++;
      if ({m_arvalid_o, m_arprot_o, m_araddr_o} !== {1'b1, ea}) begin
         n_errors++;
         $display("FAIL single_ar: got v=%b %h want v=1 %h", m_arvalid_o, {m_arprot_o, m_araddr_o}, ea);
      end
      tick();
      m_arready_i = 1'b0; s0_rready_i = 1'b1; s1_rready_i = 1'b1;
      m_rvalid_i = 1'b1; m_rdata_i = 64'hDEADBEEF_CAFEF00D; m_rresp_i = 2'b00;
      exp_q.push_back({1'b0, 2'b00, 64'hDEADBEEF_CAFEF00D});
      settle();
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if ({resp_seen(e[W-1]), m_rready_o} !== {~e[W-1], e[W-1], e[W-2:0], 1'b1}) begin
         n_errors++;
         $display("FAIL single_resp: got %h m_rready=%b want %h m_rready=1",
                  resp_seen(e[W-1]), m_rready_o, {~e[W-1], e[W-1], e[W-2:0]});
      end
      tick();
      m_rvalid_i = 1'b0;
      settle();
      n_checks++;
      if ({state_o, m_arvalid_o} !== 3'b000) begin
         n_errors++;
         $display("FAIL single_done: got state=%0d m_arvalid=%b want 0 0", state_o, m_arvalid_o);
      end
   endtask

   task automatic test_round_robin();
      logic            exp_owner;
      logic [ALEN+2:0] ea;
      logic [W-1:0]    e;
      apply_reset();
      s0_arvalid_i = 1'b1; s0_araddr_i = 64'h2000; s0_arprot_i = 3'b001;
      s1_arvalid_i = 1'b1; s1_araddr_i = 64'h3000; s1_arprot_i = 3'b010;
      s0_rready_i  = 1'b1; s1_rready_i = 1'b1;
      exp_owner = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         n_checks++;
         if ({s0_arready_o, s1_arready_o} !== (exp_owner ? 2'b01 : 2'b10)) begin
            n_errors++;
            $display("FAIL rr_grant[%0d]: got arready=%b%b want owner %0d", i, s0_arready_o, s1_arready_o, exp_owner);
         end
         ar_q.push_back(exp_owner ? {3'b010, 64'h3000} : {3'b001, 64'h2000});
         tick();
         m_arready_i = 1'b1;
         settle();
         ea = 'x;
         if (ar_q.size() != 0) ea = ar_q.pop_front();
         n_checks++;
         if ({m_arvalid_o, m_arprot_o, m_araddr_o, s0_arready_o, s1_arready_o} !== {1'b1, ea, 2'b00}) begin
            n_errors++;
            $display("FAIL rr_ar[%0d]: got v=%b %h arready=%b%b want v=1 %h arready=00",
                     i, m_arvalid_o, {m_arprot_o, m_araddr_o}, s0_arready_o, s1_arready_o, ea);
         end
         tick();
         m_arready_i = 1'b0;
         drive_resp(exp_owner, 2'b00);
         settle();
         e = 'x;
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if ({resp_seen(e[W-1]), m_rready_o, s0_arready_o, s1_arready_o} !==
             {~e[W-1], e[W-1], e[W-2:0], 1'b1, 2'b00}) begin
            n_errors++;
            $display("FAIL rr_resp[%0d]: got %h m_rready=%b arready=%b%b want %h 1 00", i,
                     resp_seen(e[W-1]), m_rready_o, s0_arready_o, s1_arready_o, {~e[W-1], e[W-1], e[W-2:0]});
         end
         tick();
         m_rvalid_i = 1'b0;
         exp_owner = ~exp_owner;
      end
      idle_inputs();
   endtask

   task automatic test_ar_stall();
      logic [ALEN+2:0] ea;
      logic [W-1:0]    e;
      idle_inputs();
      s0_arvalid_i = 1'b1; s0_araddr_i = 64'h4000; s0_arprot_i = 3'b001;
      s1_arvalid_i = 1'b1; s1_araddr_i = 64'h5000; s1_arprot_i = 3'b000;
      ar_q.push_back({3'b001, 64'h4000});
      settle();
      n_checks++;
      if ({s0_arready_o, s1_arready_o} !== 2'b10) begin
         n_errors++;
         $display("FAIL stall_grant: got arready=%b%b want 10", s0_arready_o, s1_arready_o);
      end
      tick();
      ea = 'x;
      if (ar_q.size() != 0) ea = ar_q.pop_front();
      for (int k = 0; k < 4; k++) begin
         s0_araddr_i = {$urandom, $urandom};
         s0_arprot_i = 3'($urandom_range(0, 7));
         m_arready_i = (k == 3);
         settle();
         n_checks++;
         if ({m_arvalid_o, m_arprot_o, m_araddr_o, s0_arready_o, s1_arready_o, state_o} !== {1'b1, ea, 2'b00, 2'd1}) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: got v=%b %h arready=%b%b state=%0d want v=1 %h arready=00 state=1",
                     k, m_arvalid_o, {m_arprot_o, m_araddr_o}, s0_arready_o, s1_arready_o, state_o, ea);
         end
         tick();
      end
      m_arready_i = 1'b0;
      s0_rready_i = 1'b1;
      drive_resp(1'b0, 2'b00);
      settle();
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if (resp_seen(e[W-1]) !== {~e[W-1], e[W-1], e[W-2:0]}) begin
         n_errors++;
         $display("FAIL stall_resp: got %h want %h", resp_seen(e[W-1]), {~e[W-1], e[W-1], e[W-2:0]});
      end
      tick();
      m_rvalid_i = 1'b0;
      settle();
      // s1 has waited throughout; on this tie it must now win
      n_checks++;
      if ({s0_arready_o, s1_arready_o} !== 2'b01) begin
         n_errors++;
         $display("FAIL stall_next_grant: got arready=%b%b want 01", s0_arready_o, s1_arready_o);
      end
      idle_inputs();
   endtask

   task automatic test_r_backpressure();
      logic [ALEN+2:0] ea;
      logic [W-1:0]    e;
      idle_inputs();
      s1_arvalid_i = 1'b1; s1_araddr_i = 64'h6000; s1_arprot_i = 3'b011;
      ar_q.push_back({3'b011, 64'h6000});
      settle();
      tick();
      s1_arvalid_i = 1'b0; m_arready_i = 1'b1;
      settle();
      ea = 'x;
      if (ar_q.size() != 0) ea = ar_q.pop_front();
      n_checks++;
      if ({m_arvalid_o, m_arprot_o, m_araddr_o} !== {1'b1, ea}) begin
         n_errors++;
         $display("FAIL bp_ar: got v=%b %h want v=1 %h", m_arvalid_o, {m_arprot_o, m_araddr_o}, ea);
      end
      tick();
      m_arready_i = 1'b0;
      s1_rready_i = 1'b0;
      s0_rready_i = 1'b1;   // non-owner ready must not complete the transfer
      drive_resp(1'b1, 2'b00);
      for (int k = 0; k < 2; k++) begin
         settle();
         n_checks++;
         if ({m_rready_o, s0_rvalid_o, s1_rvalid_o, state_o} !== {1'b0, 1'b0, 1'b1, 2'd2}) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: got m_rready=%b rvalid=%b%b state=%0d want 0 01 2",
                     k, m_rready_o, s0_rvalid_o, s1_rvalid_o, state_o);
         end
         tick();
      end
      s1_rready_i = 1'b1;
      settle();
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if ({resp_seen(e[W-1]), m_rready_o} !== {~e[W-1], e[W-1], e[W-2:0], 1'b1}) begin
         n_errors++;
         $display("FAIL bp_resp: got %h m_rready=%b want %h 1", resp_seen(e[W-1]), m_rready_o,
                  {~e[W-1], e[W-1], e[W-2:0]});
      end
      tick();
      m_rvalid_i = 1'b0;
      settle();
      n_checks++;
      if (state_o !== 2'd0) begin
         n_errors++;
         $display("FAIL bp_done: got state=%0d want 0", state_o);
      end
      idle_inputs();
   endtask

   task automatic test_error_passthrough();
      logic [ALEN+2:0] ea;
      logic [W-1:0]    e;
      idle_inputs();
      s1_arvalid_i = 1'b1; s1_araddr_i = 64'h7000; s1_arprot_i = 3'b000;
      settle();
      tick();
      s1_arvalid_i = 1'b0; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; s1_rready_i = 1'b1;
      drive_resp(1'b1, 2'b10);
      settle();
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if ({resp_seen(e[W-1]), m_rready_o} !== {~e[W-1], e[W-1], e[W-2:0], 1'b1}) begin
         n_errors++;
         $display("FAIL err_resp: got %h m_rready=%b want %h 1", resp_seen(e[W-1]), m_rready_o,
                  {~e[W-1], e[W-1], e[W-2:0]});
      end
      tick();
      idle_inputs();
      // follow-up tie: s1 was last, so s0 wins and completes normally
      s0_arvalid_i = 1'b1; s0_araddr_i = 64'h8000; s0_arprot_i = 3'b101;
      s1_arvalid_i = 1'b1; s1_araddr_i = 64'h8800; s1_arprot_i = 3'b110;
      ar_q.push_back({3'b101, 64'h8000});
      settle();
      n_checks++;
      if ({s0_arready_o, s1_arready_o} !== 2'b10) begin
         n_errors++;
         $display("FAIL err_next_grant: got arready=%b%b want 10", s0_arready_o, s1_arready_o);
      end
      tick();
      s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0; m_arready_i = 1'b1;
      settle();
      ea = 'x;
      if (ar_q.size() != 0) ea = ar_q.pop_front();
      n_checks++;
      if ({m_arvalid_o, m_arprot_o, m_araddr_o} !== {1'b1, ea}) begin
         n_errors++;
         $display("FAIL err_next_ar: got v=%b %h want v=1 %h", m_arvalid_o, {m_arprot_o, m_araddr_o}, ea);
      end
      tick();
      m_arready_i = 1'b0; s0_rready_i = 1'b1;
      drive_resp(1'b0, 2'b00);
      settle();
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if (resp_seen(e[W-1]) !== {~e[W-1], e[W-1], e[W-2:0]}) begin
         n_errors++;
         $display("FAIL err_next_resp: got %h want %h", resp_seen(e[W-1]), {~e[W-1], e[W-1], e[W-2:0]});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_in_resp();
      idle_inputs();
      s0_arvalid_i = 1'b1; s0_araddr_i = 64'h9000; s0_arprot_i = 3'b010;
      settle();
      tick();
      s0_arvalid_i = 1'b0; m_arready_i = 1'b1;
      tick();
      m_arready_i = 1'b0; s0_rready_i = 1'b0;
      m_rvalid_i = 1'b1; m_rdata_i = 64'h1234_5678_9ABC_DEF0;
      settle();
      n_checks++;
      if ({state_o, s0_rvalid_o} !== 3'b101) begin
         n_errors++;
         $display("FAIL rst_pre: got state=%0d s0_rvalid=%b want 2 1", state_o, s0_rvalid_o);
      end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      settle();
      n_checks++;
      if ({m_arvalid_o, m_rready_o, s0_rvalid_o, s1_rvalid_o, state_o} !== 6'b0) begin
         n_errors++;
         $display("FAIL rst_mid: got m_arvalid=%b m_rready=%b rvalid=%b%b state=%0d want 0",
                  m_arvalid_o, m_rready_o, s0_rvalid_o, s1_rvalid_o, state_o);
      end
      m_rvalid_i = 1'b0;
      s0_arvalid_i = 1'b1; s1_arvalid_i = 1'b1;
      settle();
      n_checks++;
      if ({s0_arready_o, s1_arready_o} !== 2'b10) begin
         n_errors++;
         $display("FAIL rst_tie: got arready=%b%b want 10", s0_arready_o, s1_arready_o);
      end
      idle_inputs();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rstn = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_ar_stall();
      test_r_backpressure();
      test_error_passthrough();
      test_reset_in_resp();
      n_checks++;
      if (exp_q.size() != 0 || ar_q.size() != 0) begin
         n_errors++;
         $display("FAIL queues_drained: got %0d resp / %0d ar left want 0", exp_q.size(), ar_q.size());
      end
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Two-requester arbiter that shares the single AXI-lite read port of the unified memory between the instruction-fetch unit (requester 0) and the load unit (requester 1). It accepts one read address at a time, forwards it downstream, and routes the read response back to the requester that issued it. Grants are round-robin, and only one transaction is in flight at a time. It sits between the core's fetch/load units and the memory interconnect, alongside the store path, which owns the write channels.

## Interface
- ALEN, 64, AXI address width; at least XLEN.
- DLEN, 64, AXI data width; at least XLEN.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s0_arvalid / s1_arvalid  in  1  requester read-address valid.
- s0_arready / s1_arready  out  1  requester read-address ready.
- s0_araddr / s1_araddr  in  ALEN  requester read address.
- s0_arprot / s1_arprot  in  3  requester protection bits.
- s0_rvalid / s1_rvalid  out  1  response valid to requester.
- s0_rready / s1_rready  in  1  requester response ready.
- s0_rdata / s1_rdata  out  DLEN  response data; driven from m_rdata for both requesters.
- s0_rresp / s1_rresp  out  2  response status; driven from m_rresp for both requesters.
- m_arvalid  out  1  downstream address valid.
- m_arready  in  1  downstream address ready.
- m_araddr  out  ALEN  downstream address; registered.
- m_arprot  out  3  downstream protection bits; registered.
- m_rvalid  in  1  downstream response valid.
- m_rready  out  1  downstream response ready.
- m_rdata  in  DLEN  downstream response data.
- m_rresp  in  2  downstream response status.

## Operation
- State machine with three states:
  - IDLE: no transaction in flight.
  - ADDR: m_arvalid high, waiting for m_arready.
  - RESP: waiting for the downstream response handshake.
- Grant, evaluated only in IDLE:
  - Only one sN_arvalid high: grant that requester.
  - Both high: grant the requester that is not in last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- IDLE to ADDR:
  - sN_arready = IDLE & grant[N], combinational; the non-granted requester's ready is 0.
  - On the sN handshake, register sN_araddr/sN_arprot into m_araddr/m_arprot, set m_arvalid, latch owner = N, set last_grant = N, go to ADDR.
- ADDR to RESP: on m_arvalid & m_arready, clear m_arvalid and go to RESP. m_araddr/m_arprot hold stable while m_arvalid is high.
- RESP, combinational routing:
  - sN_rvalid = m_rvalid & (owner==N); the other requester's rvalid is 0.
  - m_rready = s[owner]_rready.
  - rdata/rresp pass through unmodified; no error handling here.
- RESP to IDLE: on m_rvalid & m_rready. A new grant is possible in the following cycle, never in the same cycle.
- m_rvalid seen outside RESP is a protocol violation: ignore it (m_rready=0) and emit $error in simulation.
- Reset values: m_arvalid=0, m_araddr=0, m_arprot=0, state=IDLE, owner=0, last_grant=1. Combinational outputs follow from these: s*_arready=0, s*_rvalid=0, m_rready=0.
- Reset mid-transaction returns to IDLE and drops any in-flight response. The downstream slave must share the same reset.

## Timing
- Request accepted in cycle T; m_arvalid rises in T+1.
- Minimum occupancy is 3 cycles: accept in T, AR handshake in T+1, R handshake in T+2, next accept in T+3.
- Backpressure is passed through with zero added latency on R. AR adds one registered stage.
- arvalid on a non-granted requester may stay high indefinitely. It is granted at the next IDLE because of round-robin.

## Test plan
- Single request: s0 requests 0x1000 with prot=3'b100. Required: s0_arready high in T; m_araddr=0x1000 and m_arprot=3'b100 in T+1; m_rdata=0xDEADBEEF_CAFEF00D, rresp=0 is delivered to s0 only, s1_rvalid stays 0.
- Simultaneous requests after reset: s0 and s1 hold arvalid for 4 transactions. Required: grant order 0,1,0,1; each response reaches the correct owner.
- AR stall: m_arready low for 3 cycles. Required: m_arvalid and m_araddr stable throughout; both sN_arready stay 0 until return to IDLE.
- R backpressure: owner s1 holds rready=0 for 2 cycles while m_rvalid=1. Required: m_rready=0 in those cycles and the state stays RESP; completion in the cycle s1_rready rises.
- Error passthrough: m_rresp=2'b10 in RESP for s1. Required: s1_rresp=2'b10 in the handshake cycle and the next grant proceeds normally.
- Reset in RESP: rstn=0 for 1 cycle. Required: next cycle m_arvalid=0, m_rready=0, both s*_rvalid=0; a subsequent tie grants s0.
